// File: rtl/mfcc_mean_accum_pkg.sv
// Shared defaults and FSM encoding for the MFCC mean accumulator.
package mfcc_mean_accum_pkg;

  localparam int NUM_COEF_DEF   = 13;
  localparam int COEF_W_DEF     = 16;
  localparam int FRM_W_DEF      = 8;
  localparam int MIN_FRAMES_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DIVIDE = 2'd2,
    S_EMIT   = 2'd3
  } state_e;

endpackage

// File: rtl/mfcc_mean_div.sv
// Serial restoring divider: signed dividend by unsigned divisor, one load cycle + ACC_W steps.
// MFCC_MEAN_ROUND_EN: add divisor/2 to |dividend| for round-half-away-from-zero.
module mfcc_mean_div #(
  parameter int ACC_W = 24,
  parameter int FRM_W = 8,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  input  logic [FRM_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] quotient
);
  localparam int CNT_W = $clog2(ACC_W + 1);

  logic             busy_q, busy_d;
  logic             neg_q, neg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FRM_W-1:0] rem_q, rem_d;
  logic [FRM_W-1:0] dvs_q, dvs_d;
  logic [ACC_W-1:0] quo_q, quo_d;
  logic [ACC_W-1:0] mag;
  logic [FRM_W:0]   rem_sh;
  logic             ge;

  always_comb begin
    mag = dividend[ACC_W-1] ? (~dividend + 1'b1) : dividend;
`ifdef MFCC_MEAN_ROUND_EN
    mag = mag + ACC_W'(divisor >> 1);
`endif
    rem_sh = {rem_q, quo_q[ACC_W-1]};
    ge     = rem_sh >= {1'b0, dvs_q};
    busy_d = busy_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    if (busy_q) begin
      // The difference always fits FRM_W bits since the new remainder is < divisor.
      rem_d = ge ? (rem_sh[FRM_W-1:0] - dvs_q) : rem_sh[FRM_W-1:0];
      quo_d = {quo_q[ACC_W-2:0], ge};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      neg_d  = dividend[ACC_W-1];
      cnt_d  = CNT_W'(ACC_W);
      rem_d  = '0;
      dvs_d  = divisor;
      quo_d  = mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      neg_q  <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
    end else begin
      busy_q <= busy_d;
      neg_q  <= neg_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == CNT_W'(1));
  assign quotient = neg_q ? (~quo_q[OUT_W-1:0] + 1'b1) : quo_q[OUT_W-1:0];

endmodule

// File: rtl/mfcc_mean_accum.sv
// Sums MFCC coefficients over voiced frames of an utterance, then emits per-index means.
// Rounding mode is selected inside mfcc_mean_div (MFCC_MEAN_ROUND_EN).
module mfcc_mean_accum
  import mfcc_mean_accum_pkg::*;
#(
  parameter int NUM_COEF   = NUM_COEF_DEF,
  parameter int COEF_W     = COEF_W_DEF,
  parameter int FRM_W      = FRM_W_DEF,
  parameter int MIN_FRAMES = MIN_FRAMES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              vad_active,
  input  logic [COEF_W-1:0] coef_in,
  input  logic              coef_valid,
  input  logic              coef_last,
  output logic [COEF_W-1:0] mfcc_means,
  output logic              mfcc_means_valid,
  output logic              data_hi,
  output logic              busy
);
  localparam int ACC_W = COEF_W + FRM_W;
  localparam int IDX_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam logic [FRM_W-1:0] FRM_MAX  = '1;
  localparam logic [FRM_W-1:0] FRM_MIN  = FRM_W'(MIN_FRAMES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_COEF - 1);

  state_e                          state_q, state_d;
  logic [NUM_COEF-1:0][ACC_W-1:0]  acc_q, acc_d;
  logic [FRM_W-1:0]                frame_cnt_q, frame_cnt_d;
  logic [IDX_W-1:0]                coef_idx_q, coef_idx_d;
  logic [IDX_W-1:0]                out_idx_q, out_idx_d;
  logic                            frm_keep_q, frm_keep_d;
  logic [COEF_W-1:0]               mfcc_means_q, mfcc_means_d;
  logic                            means_valid_q, means_valid_d;
  logic                            data_hi_q, data_hi_d;
  logic                            busy_q, busy_d;
  logic                            keep_now;
  logic [ACC_W-1:0]                coef_ext;
  logic                            div_start, div_busy, div_done;
  logic [COEF_W-1:0]               div_quot;

  assign coef_ext = {{FRM_W{coef_in[COEF_W-1]}}, coef_in};

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    frame_cnt_d   = frame_cnt_q;
    coef_idx_d    = coef_idx_q;
    out_idx_d     = out_idx_q;
    frm_keep_d    = frm_keep_q;
    mfcc_means_d  = '0;
    means_valid_d = 1'b0;
    div_start     = 1'b0;
    keep_now      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d       = '0;
          frame_cnt_d = '0;
          coef_idx_d  = '0;
          out_idx_d   = '0;
          frm_keep_d  = 1'b0;
          state_d     = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (coef_valid) begin
          if (coef_idx_q == '0 && !vad_active && frame_cnt_q >= FRM_MIN) begin
            state_d = S_DIVIDE;
          end else begin
            keep_now = (coef_idx_q == '0) ? vad_active : frm_keep_q;
            if (coef_idx_q == '0) begin
              frm_keep_d = vad_active;
              // Unvoiced frame after a too-short burst: discard the burst as noise.
              if (!vad_active && frame_cnt_q != '0) begin
                acc_d       = '0;
                frame_cnt_d = '0;
              end
            end
            if (keep_now) acc_d[coef_idx_q] = acc_q[coef_idx_q] + coef_ext;
            if (coef_last || coef_idx_q == IDX_LAST) begin
              coef_idx_d = '0;
              if (keep_now) begin
                if (frame_cnt_q != FRM_MAX) frame_cnt_d = frame_cnt_q + 1'b1;
                if (frame_cnt_d == FRM_MAX) state_d = S_DIVIDE;
              end
            end else begin
              coef_idx_d = coef_idx_q + 1'b1;
            end
          end
        end
      end
      S_DIVIDE: begin
        div_start = !div_busy;
        if (div_done) state_d = S_EMIT;
      end
      S_EMIT: begin
        mfcc_means_d  = div_quot;
        means_valid_d = 1'b1;
        if (out_idx_q == IDX_LAST) begin
          state_d = S_IDLE;
        end else begin
          out_idx_d = out_idx_q + 1'b1;
          state_d   = S_DIVIDE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    data_hi_d = (state_d == S_ACCUM) && (frame_cnt_d >= FRM_MIN);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_q         <= '0;
      frame_cnt_q   <= '0;
      coef_idx_q    <= '0;
      out_idx_q     <= '0;
      frm_keep_q    <= 1'b0;
      mfcc_means_q  <= '0;
      means_valid_q <= 1'b0;
      data_hi_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      frame_cnt_q   <= frame_cnt_d;
      coef_idx_q    <= coef_idx_d;
      out_idx_q     <= out_idx_d;
      frm_keep_q    <= frm_keep_d;
      mfcc_means_q  <= mfcc_means_d;
      means_valid_q <= means_valid_d;
      data_hi_q     <= data_hi_d;
      busy_q        <= busy_d;
    end
  end

  mfcc_mean_div #(
    .ACC_W (ACC_W),
    .FRM_W (FRM_W),
    .OUT_W (COEF_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (acc_q[out_idx_q]),
    .divisor  (frame_cnt_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quot)
  );

  assign mfcc_means       = mfcc_means_q;
  assign mfcc_means_valid = means_valid_q;
  assign data_hi          = data_hi_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_mfcc_mean_accum.sv
// Scoreboard bench for mfcc_mean_accum: frame-level reference model feeds an expected-mean queue.
module tb_mfcc_mean_accum;
  localparam int NUM_COEF   = 13;
  localparam int COEF_W     = 16;
  localparam int FRM_W      = 8;
  localparam int MIN_FRAMES = 8;
  localparam int ACC_W      = COEF_W + FRM_W;
  localparam int SPACING    = ACC_W + 2;
  localparam int FRM_MAX    = (1 << FRM_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              vad_active = 1'b0;
  logic [COEF_W-1:0] coef_in = '0;
  logic              coef_valid = 1'b0;
  logic              coef_last = 1'b0;
  logic [COEF_W-1:0] mfcc_means;
  logic              mfcc_means_valid;
  logic              data_hi;
  logic              busy;

  mfcc_mean_accum dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .vad_active       (vad_active),
    .coef_in          (coef_in),
    .coef_valid       (coef_valid),
    .coef_last        (coef_last),
    .mfcc_means       (mfcc_means),
    .mfcc_means_valid (mfcc_means_valid),
    .data_hi          (data_hi),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int mean; int at;} exp_t;
  exp_t exq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_strobes = 0;
  int drv_cyc  = 0;
  int msum[NUM_COEF];
  int mcnt = 0;
  int fv[NUM_COEF];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Mean as defined on the utterance sums: magnitude division, sign reapplied.
  function automatic int ref_mean(input int s, input int n);
    int a;
    int m;
    a = (s < 0) ? -s : s;
`ifdef MFCC_MEAN_ROUND_EN
    a = a + n / 2;
`endif
    m = a / n;
    return (s < 0) ? -m : m;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NUM_COEF; k++) msum[k] = 0;
    mcnt = 0;
  endtask

  task automatic push_exp(input int trig);
    for (int k = 0; k < NUM_COEF; k++)
      exq.push_back('{mean: ref_mean(msum[k], mcnt), at: trig + ACC_W + 3 + k * SPACING});
    model_clear();
  endtask

  always @(negedge clk) begin
    if (mfcc_means_valid === 1'b1) begin
      if (exq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: got mean %0d, expected no strobe (cycle %0d)",
                 $signed(mfcc_means), cyc);
      end else begin
        exp_t e;
        e = exq.pop_front();
        chk("mean_value", $signed(mfcc_means), e.mean);
        chk("strobe_cycle", cyc, e.at);
      end
      n_strobes++;
    end
  end

  task automatic drive(input int v, input bit vad, input bit last);
    if ($urandom_range(0, 3) == 0) begin
      @(negedge clk);
      coef_valid = 1'b0;
      vad_active = 1'($urandom_range(0, 1));
      coef_last  = 1'($urandom_range(0, 1));
      coef_in    = COEF_W'($urandom);
    end
    @(negedge clk);
    coef_valid = 1'b1;
    coef_in    = COEF_W'(v);
    vad_active = vad;
    coef_last  = last;
    drv_cyc    = cyc;
  endtask

  task automatic idle1();
    @(negedge clk);
    coef_valid = 1'b0;
    coef_last  = 1'b0;
  endtask

  task automatic send_frame(input bit vad_first, input bit vad_rest, input int len);
    idle1();
    chk("busy_accum", busy, 1);
    chk("data_hi", data_hi, (mcnt >= MIN_FRAMES) ? 1 : 0);
    if (!vad_first && mcnt >= MIN_FRAMES) begin
      drive(fv[0], 1'b0, len == 1);
      push_exp(drv_cyc);
      idle1();
      return;
    end
    if (!vad_first && mcnt > 0) model_clear();
    for (int i = 0; i < len; i++) begin
      drive(fv[i], (i == 0) ? vad_first : vad_rest, i == len - 1);
      if (vad_first) msum[i] += fv[i];
    end
    if (vad_first) begin
      mcnt++;
      if (mcnt == FRM_MAX) begin
        push_exp(drv_cyc);
        idle1();
      end
    end
  endtask

  task automatic rand_fv();
    for (int k = 0; k < NUM_COEF; k++) fv[k] = int'($urandom_range(0, 60000)) - 30000;
  endtask

  task automatic end_utt();
    rand_fv();
    send_frame(1'b0, 1'b0, NUM_COEF);
  endtask

  task automatic start_cap();
    @(negedge clk);
    coef_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while ((exq.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_pending"}, exq.size(), 0);
    repeat (3) @(negedge clk);
    chk({name, "_busy_low"}, busy, 0);
    chk({name, "_data_hi_low"}, data_hi, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n;
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_means", mfcc_means, 0);
    chk("rst_valid", mfcc_means_valid, 0);
    chk("rst_data_hi", data_hi, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Ramp 100*k over 10 frames; a start pulse mid-capture must be ignored.
    start_cap();
    for (int k = 0; k < NUM_COEF; k++) fv[k] = 100 * k;
    for (int f = 0; f < 10; f++) begin
      send_frame(1'b1, 1'b1, NUM_COEF);
      if (f == 3) begin
        @(negedge clk);
        coef_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    end_utt();
    wait_done("ramp");

    // Sum of -13 over 8 frames in coefficient 0.
    start_cap();
    for (int k = 0; k < NUM_COEF; k++) fv[k] = 0;
    fv[0] = -2;
    for (int f = 0; f < 7; f++) send_frame(1'b1, 1'b1, NUM_COEF);
    fv[0] = 1;
    send_frame(1'b1, 1'b1, NUM_COEF);
    end_utt();
    wait_done("signed");

    // Short burst rejected as noise, then a real burst of constant 50.
    start_cap();
    for (int f = 0; f < 3; f++) begin rand_fv(); send_frame(1'b1, 1'b1, NUM_COEF); end
    for (int f = 0; f < 2; f++) begin rand_fv(); send_frame(1'b0, 1'b1, NUM_COEF); end
    for (int k = 0; k < NUM_COEF; k++) fv[k] = 50;
    for (int f = 0; f < 8; f++) send_frame(1'b1, 1'b1, NUM_COEF);
    end_utt();
    wait_done("noise");

    // Skipped frame (vad low only on its first coefficient), then short frames.
    start_cap();
    rand_fv();
    send_frame(1'b0, 1'b1, NUM_COEF);
    for (int f = 0; f < 9; f++) begin
      rand_fv();
      send_frame(1'b1, 1'b1, int'($urandom_range(1, NUM_COEF)));
    end
    end_utt();
    wait_done("skip");

    for (int u = 0; u < 2; u++) begin
      start_cap();
      n = int'($urandom_range(MIN_FRAMES, 20));
      for (int f = 0; f < n; f++) begin
        rand_fv();
        send_frame(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(1, NUM_COEF)));
      end
      end_utt();
      wait_done("random");
    end

    // Frame counter saturation ends the utterance with vad still high.
    start_cap();
    for (int k = 0; k < NUM_COEF; k++) fv[k] = 7;
    for (int f = 0; f < FRM_MAX; f++) send_frame(1'b1, 1'b1, NUM_COEF);
    wait_done("saturate");

    // Reset after the fifth strobe aborts the output sequence.
    start_cap();
    for (int f = 0; f < 8; f++) begin rand_fv(); send_frame(1'b1, 1'b1, NUM_COEF); end
    end_utt();
    base = n_strobes;
    n = 0;
    while (n_strobes < base + 5 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("five_strobes_seen", n_strobes - base, 5);
    @(negedge clk);
    rst = 1'b1;
    exq.delete();
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_data_hi", data_hi, 0);
    chk("rst_mid_valid", mfcc_means_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    base = n_strobes;
    repeat (60) @(negedge clk);
    chk("no_strobes_after_rst", n_strobes - base, 0);
    start_cap();
    for (int f = 0; f < 9; f++) begin rand_fv(); send_frame(1'b1, 1'b1, NUM_COEF); end
    end_utt();
    wait_done("fresh");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
